rpn_sequencer: RTL and testbench
================================

Name: rpn_sequencer

Overview:
- Token-driven evaluator that sits directly upstream of the 13-bit, 8-entry operand stack and is the only block that drives it.
- Takes a stream of operand/operator tokens, issues push/pop strobes to the stack, and performs binary arithmetic on the popped operands. Results are pushed back, or emitted on EVAL.
- Tracks stack depth itself and rejects underflow, overflow and illegal opcodes before any stack access.

Parameters:
B, 13, data/operand width (two's complement)
L, 8, stack depth; must match the stack instance

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  reset, asynchronous, active-high
tok_valid  in  1  token present
tok_ready  out  1  sequencer accepts token this cycle
tok_is_op  in  1  1 = operator token, 0 = operand token
tok_data  in  B  operand value, or opcode in [2:0] when tok_is_op=1
stk_push  out  1  one-cycle push strobe to stack
stk_pop  out  1  one-cycle pop strobe to stack
stk_wdata  out  B  data to push; valid while stk_push=1
stk_rdata  in  B  stack read data; valid the cycle after stk_pop
res_valid  out  1  one-cycle result pulse (EVAL)
res_data  out  B  result value; held until next EVAL
err_valid  out  1  one-cycle error pulse
err_code  out  2  01 underflow, 10 overflow, 11 illegal opcode; held until next error
depth  out  $clog2(L)+1  current stack occupancy, 0..L

Behaviour:
- Reset (async):
  - state=IDLE, depth=0.
  - stk_push, stk_pop, res_valid and err_valid all 0.
  - res_data=0, err_code=0, stk_wdata=0.
  - tok_ready=0 while reset is asserted.
- Reset mid-operation aborts the in-flight token with no push. The stack shares the same reset, so depth=0 stays consistent with it.
- tok_ready=1 only in IDLE with reset deasserted. A token is accepted on a cycle where tok_valid && tok_ready.
- Opcodes: 000 ADD, 001 SUB, 010 MUL, 011 AND, 100 OR, 101 EVAL; 110 and 111 are illegal.
- States: IDLE, POP_B, POP_A, EXEC, PUSH, EMIT, ERR.
- Operand token, accepted at cycle T:
  - If depth==L: ERR.
  - Else PUSH at T+1: stk_push=1, stk_wdata=tok_data, depth+1.
  - IDLE at T+2.
- Binary operator, accepted at T:
  - If depth<2: ERR.
  - T+1 POP_B: stk_pop=1.
  - T+2 POP_A: capture b=stk_rdata, stk_pop=1.
  - T+3 EXEC: capture a=stk_rdata, compute r=a op b and register it.
  - T+4 PUSH: stk_push=1, stk_wdata=r.
  - IDLE at T+5.
  - Net depth change is -1: decrement by 1 per pop, increment by 1 on push.
- Operand order: b is the old top-of-stack, so SUB yields a-b (the deeper operand minus the top).
- EVAL, accepted at T:
  - If depth<1: ERR.
  - T+1 POP_B: stk_pop=1, depth-1.
  - T+2 EMIT: res_data=stk_rdata, res_valid=1.
  - IDLE at T+3.
- Arithmetic:
  - All ops are modulo 2^B.
  - ADD/SUB wrap.
  - MUL keeps the low B bits of the 2B-bit product.
  - AND/OR are bitwise.
  - No arithmetic-overflow flag.
- ERR state:
  - Lasts one cycle: err_valid=1, err_code set.
  - The token is consumed; no stack strobe; depth unchanged.
  - Returns to IDLE.
- Error priority: illegal opcode > underflow. Overflow applies only to operand tokens.
- Binary ops never overflow: the result push follows two pops.
- stk_push and stk_pop are never high in the same cycle, and never high in IDLE.
- Throughput: one token in flight.
  - Operand: 2 cycles.
  - Binary operator: 5 cycles.
  - EVAL: 3 cycles.
  - Error: 2 cycles.

Decomposition:
- Package rpn_pkg holds:
  - typedef opcode_t (3-bit enum: ADD, SUB, MUL, AND, OR, EVAL).
  - typedef err_t (2-bit enum: NONE, UNDERFLOW, OVERFLOW, ILLEGAL).
  - typedef state_t.
  - Constant DATA_W=13.
- Sub-module rpn_alu: combinational. Inputs a, b, opcode; output r of width B. Instantiated once and registered in EXEC.

Test Plan:
- Push 5, push 3, SUB, EVAL -> stk_push twice (wdata 5, 3); pops; push wdata 2; res_valid pulse with res_data=2; depth ends 0.
- Push 4095, push 2, MUL -> pushed result = 8190 mod 8192 = 8190 (0x1FFE); push 8191, push 1, ADD -> result 0 (wrap).
- EVAL with depth=0 -> err_valid pulse, err_code=01, no stk_pop, depth stays 0, tok_ready high 2 cycles after acceptance.
- Push 8 operands (depth=8), push a 9th -> err_code=10, no stk_push, depth stays 8; then ADD succeeds, depth=7.
- Opcode 110 with depth=3 -> err_code=11, no stack strobes, depth 3.
- Assert reset during EXEC of ADD -> outputs zero immediately (async), no push; after release depth=0, tok_ready=1; check stk_push/stk_pop never both high.

Source files
------------

// File: rtl/rpn_pkg.sv
// Shared types and constants for the RPN token sequencer and its ALU.
package rpn_pkg;

  localparam int unsigned DATA_W  = 13;
  localparam int unsigned STACK_L = 8;

  typedef enum logic [2:0] {
    OpAdd  = 3'd0,
    OpSub  = 3'd1,
    OpMul  = 3'd2,
    OpAnd  = 3'd3,
    OpOr   = 3'd4,
    OpEval = 3'd5
  } opcode_t;

  typedef enum logic [1:0] {
    ErrNone      = 2'b00,
    ErrUnderflow = 2'b01,
    ErrOverflow  = 2'b10,
    ErrIllegal   = 2'b11
  } err_t;

  typedef enum logic [2:0] {
    StIdle,
    StPopB,
    StPopA,
    StExec,
    StPush,
    StEmit,
    StErr
  } state_t;

  function automatic logic op_is_legal(input logic [2:0] raw);
    return raw <= 3'd5;
  endfunction

endpackage

// File: rtl/rpn_sequencer_if.sv
// Token stream, stack strobes, result and error signals of the sequencer.
interface rpn_sequencer_if import rpn_pkg::*; #(
  parameter int unsigned B = DATA_W,
  parameter int unsigned L = STACK_L
) ();

  localparam int unsigned DepthW = $clog2(L) + 1;

  logic              tok_valid;
  logic              tok_ready;
  logic              tok_is_op;
  logic [B-1:0]      tok_data;
  logic              stk_push;
  logic              stk_pop;
  logic [B-1:0]      stk_wdata;
  logic [B-1:0]      stk_rdata;
  logic              res_valid;
  logic [B-1:0]      res_data;
  logic              err_valid;
  logic [1:0]        err_code;
  logic [DepthW-1:0] depth;

  modport slave (
    input  tok_valid, tok_is_op, tok_data, stk_rdata,
    output tok_ready, stk_push, stk_pop, stk_wdata, res_valid, res_data,
           err_valid, err_code, depth
  );

  modport master (
    output tok_valid, tok_is_op, tok_data, stk_rdata,
    input  tok_ready, stk_push, stk_pop, stk_wdata, res_valid, res_data,
           err_valid, err_code, depth
  );

endinterface

// File: rtl/rpn_alu.sv
// Combinational binary ALU; all results are modulo 2^B.
module rpn_alu import rpn_pkg::*; #(
  parameter int unsigned B = DATA_W
) (
  input  logic [B-1:0] a_i,
  input  logic [B-1:0] b_i,
  input  opcode_t      op_i,
  output logic [B-1:0] r_o
);

  always_comb begin
    r_o = '0;
    case (op_i)
      OpAdd:   r_o = a_i + b_i;
      OpSub:   r_o = a_i - b_i;
      OpMul:   r_o = a_i * b_i;
      OpAnd:   r_o = a_i & b_i;
      OpOr:    r_o = a_i | b_i;
      default: r_o = '0;
    endcase
  end

endmodule

// File: rtl/rpn_sequencer.sv
// Token-driven RPN evaluator; sole driver of the downstream operand stack.
module rpn_sequencer import rpn_pkg::*; #(
  parameter int unsigned B = DATA_W,
  parameter int unsigned L = STACK_L
) (
  input logic           clk,
  input logic           reset,
  rpn_sequencer_if.slave bus
);

  localparam int unsigned DepthW = $clog2(L) + 1;

  state_t            state_q, state_d;
  logic [DepthW-1:0] depth_q, depth_d;
  opcode_t           op_q, op_d;
  logic [B-1:0]      b_q, b_d;
  logic [B-1:0]      wdata_q, wdata_d;
  logic [B-1:0]      res_q, res_d;
  err_t              err_q, err_d;
  logic [B-1:0]      alu_r;
  logic [DepthW-1:0] need_depth;

  // a comes straight from the stack read port in EXEC; b was captured in POP_A
  rpn_alu #(.B(B)) u_alu (
    .a_i  (bus.stk_rdata),
    .b_i  (b_q),
    .op_i (op_q),
    .r_o  (alu_r)
  );

  always_comb begin
    state_d    = state_q;
    depth_d    = depth_q;
    op_d       = op_q;
    b_d        = b_q;
    wdata_d    = wdata_q;
    res_d      = res_q;
    err_d      = err_q;
    need_depth = (bus.tok_data[2:0] == OpEval) ? DepthW'(1) : DepthW'(2);
    case (state_q)
      StIdle: begin
        if (bus.tok_valid) begin
          if (!bus.tok_is_op) begin
            if (depth_q == DepthW'(L)) begin
              err_d   = ErrOverflow;
              state_d = StErr;
            end else begin
              wdata_d = bus.tok_data;
              state_d = StPush;
            end
          end else if (!op_is_legal(bus.tok_data[2:0])) begin
            err_d   = ErrIllegal;
            state_d = StErr;
          end else if (depth_q < need_depth) begin
            err_d   = ErrUnderflow;
            state_d = StErr;
          end else begin
            op_d    = opcode_t'(bus.tok_data[2:0]);
            state_d = StPopB;
          end
        end
      end
      StPopB: begin
        depth_d = depth_q - DepthW'(1);
        state_d = (op_q == OpEval) ? StEmit : StPopA;
      end
      StPopA: begin
        b_d     = bus.stk_rdata;
        depth_d = depth_q - DepthW'(1);
        state_d = StExec;
      end
      StExec: begin
        wdata_d = alu_r;
        state_d = StPush;
      end
      StPush: begin
        depth_d = depth_q + DepthW'(1);
        state_d = StIdle;
      end
      StEmit: begin
        res_d   = bus.stk_rdata;
        state_d = StIdle;
      end
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      depth_q <= '0;
      op_q    <= OpAdd;
      b_q     <= '0;
      wdata_q <= '0;
      res_q   <= '0;
      err_q   <= ErrNone;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      op_q    <= op_d;
      b_q     <= b_d;
      wdata_q <= wdata_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    bus.tok_ready = (state_q == StIdle) && !reset;
    bus.stk_push  = (state_q == StPush);
    bus.stk_pop   = (state_q == StPopB) || (state_q == StPopA);
    bus.stk_wdata = wdata_q;
    bus.res_valid = (state_q == StEmit);
    // Result is presented during the EMIT pulse, then held from res_q
    bus.res_data  = (state_q == StEmit) ? bus.stk_rdata : res_q;
    bus.err_valid = (state_q == StErr);
    bus.err_code  = err_q;
    bus.depth     = depth_q;
  end

endmodule

// File: tb/tb_rpn_sequencer.sv
// Scoreboard bench: a token-level reference model queues expected stack/result/error events.
module tb_rpn_sequencer;
  import rpn_pkg::*;

  localparam int unsigned B    = 13;
  localparam int unsigned L    = 8;
  localparam int          Mask = (1 << B) - 1;
  localparam int EvPush = 0, EvPop = 1, EvRes = 2, EvErr = 3;

  typedef struct {
    int kind;
    int data;
  } ev_t;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  ev_t  exp_q[$];
  int   ref_stk[$];
  logic [B-1:0] mem[$];

  rpn_sequencer_if #(.B(B), .L(L)) bus ();

  rpn_sequencer #(.B(B), .L(L)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stack: read data appears the cycle after the pop strobe
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mem.delete();
      bus.stk_rdata <= '0;
    end else begin
      if (bus.stk_pop && mem.size() > 0) begin
        bus.stk_rdata <= mem[$];
        void'(mem.pop_back());
      end
      if (bus.stk_push) mem.push_back(bus.stk_wdata);
    end
  end

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic push_ev(input int kind, input int data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic expect_ev(input int kind, input int data);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_event_kind", kind, -1);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      if (e.kind != EvPop) chk("event_data", data, e.data);
    end
  endtask

  // Monitor: every DUT strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (!reset) begin
      chk("push_pop_exclusive", int'(bus.stk_push & bus.stk_pop), 0);
      chk("strobe_in_idle", int'(bus.tok_ready & (bus.stk_push | bus.stk_pop)), 0);
      if (bus.stk_push)  expect_ev(EvPush, int'(bus.stk_wdata));
      if (bus.stk_pop)   expect_ev(EvPop, 0);
      if (bus.res_valid) expect_ev(EvRes, int'(bus.res_data));
      if (bus.err_valid) expect_ev(EvErr, int'(bus.err_code));
    end
  end

  // Token-level reference: stack of ints, arithmetic modulo 2^B
  task automatic ref_token(input bit is_op, input int data, output int lat);
    int c, a, b, r;
    longint p;
    lat = 2;
    if (!is_op) begin
      if (ref_stk.size() == L) begin
        push_ev(EvErr, 2);
      end else begin
        ref_stk.push_back(data & Mask);
        push_ev(EvPush, data & Mask);
      end
    end else begin
      c = data & 7;
      if (c > 5) begin
        push_ev(EvErr, 3);
      end else if (c == 5) begin
        if (ref_stk.size() < 1) begin
          push_ev(EvErr, 1);
        end else begin
          a = ref_stk.pop_back();
          push_ev(EvPop, 0);
          push_ev(EvRes, a);
          lat = 3;
        end
      end else if (ref_stk.size() < 2) begin
        push_ev(EvErr, 1);
      end else begin
        b = ref_stk.pop_back();
        a = ref_stk.pop_back();
        case (c)
          0: r = (a + b) & Mask;
          1: r = (a - b) & Mask;
          2: begin p = longint'(a) * longint'(b); r = int'(p & longint'(Mask)); end
          3: r = a & b;
          default: r = a | b;
        endcase
        ref_stk.push_back(r);
        push_ev(EvPop, 0);
        push_ev(EvPop, 0);
        push_ev(EvPush, r);
        lat = 5;
      end
    end
  endtask

  task automatic send(input bit is_op, input int data);
    int exp_lat, n;
    ref_token(is_op, data, exp_lat);
    @(negedge clk);
    bus.tok_valid = 1'b1;
    bus.tok_is_op = is_op;
    bus.tok_data  = B'(data);
    n = 0;
    while (!bus.tok_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", int'(bus.tok_ready), 1);
    @(posedge clk);
    #1 bus.tok_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.tok_ready && n < 20);
    chk("token_latency", n, exp_lat);
    chk("depth", int'(bus.depth), ref_stk.size());
  endtask

  task automatic send_op(input int code);
    send(1'b1, int'($urandom_range(0, 1023)) * 8 + code);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    errors = 0;
    checks = 0;
    bus.tok_valid = 1'b0;
    bus.tok_is_op = 1'b0;
    bus.tok_data  = '0;
    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_tok_ready", int'(bus.tok_ready), 0);
    chk("rst_depth", int'(bus.depth), 0);
    chk("rst_push", int'(bus.stk_push), 0);
    chk("rst_pop", int'(bus.stk_pop), 0);
    chk("rst_res_valid", int'(bus.res_valid), 0);
    chk("rst_err_valid", int'(bus.err_valid), 0);
    chk("rst_res_data", int'(bus.res_data), 0);
    chk("rst_err_code", int'(bus.err_code), 0);
    chk("rst_wdata", int'(bus.stk_wdata), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", int'(bus.tok_ready), 1);

    // 5 3 SUB EVAL -> 2
    send(1'b0, 5); send(1'b0, 3); send_op(1); send_op(5);
    // MUL keeps low bits; ADD wraps
    send(1'b0, 4095); send(1'b0, 2); send_op(2); send_op(5);
    send(1'b0, 8191); send(1'b0, 1); send_op(0); send_op(5);
    // EVAL on empty stack
    send_op(5);
    // Fill, overflow, then a binary op still works
    for (int i = 0; i < 9; i++) send(1'b0, int'($urandom_range(0, Mask)));
    send_op(0);
    repeat (4) send_op(5);
    send_op(6);
    send_op(7);
    while (ref_stk.size() > 0) send_op(5);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 0) send(1'b0, int'($urandom_range(0, Mask)));
      else send_op(int'($urandom_range(0, 7)));
    end
    while (ref_stk.size() > 0) send_op(5);

    // Reset in EXEC of an ADD aborts the push
    send(1'b0, 1); send(1'b0, 2);
    push_ev(EvPop, 0);
    push_ev(EvPop, 0);
    ref_stk.delete();
    @(negedge clk);
    bus.tok_valid = 1'b1;
    bus.tok_is_op = 1'b1;
    bus.tok_data  = B'(0);
    @(posedge clk);
    #1 bus.tok_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_push", int'(bus.stk_push), 0);
    chk("midrst_pop", int'(bus.stk_pop), 0);
    chk("midrst_tok_ready", int'(bus.tok_ready), 0);
    chk("midrst_depth", int'(bus.depth), 0);
    chk("midrst_wdata", int'(bus.stk_wdata), 0);
    chk("midrst_pending", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", int'(bus.tok_ready), 1);
    chk("post_rst_depth", int'(bus.depth), 0);
    send(1'b0, 7); send_op(5);

    repeat (3) @(negedge clk);
    chk("queue_empty_end", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
